// File: rtl/aes_mode_stream_ctrl.sv
// Streaming block-cipher mode controller (ECB/CBC/CFB/OFB/CTR) wrapped around an
// external AES block core. One block is in flight at a time: accept an input block,
// run it through the core, present the result, then return for the next block.
module aes_mode_stream_ctrl #(
   parameter int BLK_W = 128,
   parameter int CTR_W = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             decipher,
   input  logic [2:0]       mode,
   input  logic [BLK_W-1:0] init_vector,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BLK_W-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BLK_W-1:0] out_data,
   output logic             out_last,
   output logic             core_start,
   output logic             core_decipher,
   output logic [BLK_W-1:0] core_din,
   input  logic [BLK_W-1:0] core_dout,
   input  logic             core_done,
   output logic             busy,
   output logic             err_mode,
   output logic [CNT_W-1:0] blk_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_IN = 2'd1,
      ST_CORE    = 2'd2,
      ST_OUT     = 2'd3
   } state_t;

   localparam logic [2:0] MODE_ECB = 3'd0;
   localparam logic [2:0] MODE_CBC = 3'd1;
   localparam logic [2:0] MODE_CFB = 3'd2;
   localparam logic [2:0] MODE_OFB = 3'd3;
   localparam logic [2:0] MODE_CTR = 3'd4;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [2:0]       mode_r;
   logic             decipher_r;
   logic [BLK_W-1:0] chain_r;
   logic [BLK_W-1:0] in_data_r;
   logic             in_last_r;
   logic [BLK_W-1:0] out_data_r;
   logic             out_last_r;
   logic             out_valid_r;
   logic             in_ready_r;
   logic             core_start_r;
   logic             core_decipher_r;
   logic [BLK_W-1:0] core_din_r;
   logic             busy_r;
   logic             err_mode_r;
   logic [CNT_W-1:0] blk_cnt_r;

   logic             start_ok_s;
   logic             start_bad_s;
   logic             in_fire_s;
   logic             done_s;
   logic             out_fire_s;
   logic [BLK_W-1:0] din_s;
   logic             core_dec_s;
   logic [BLK_W-1:0] res_s;
   logic [BLK_W-1:0] chain_upd_s;
   logic [CTR_W-1:0] ctr_inc_s;

   // Qualified events; abort masks a same-cycle start so it is fully ignored.
   always_comb begin
      start_ok_s  = start && !abort && (state_r == ST_IDLE) && (mode <= MODE_CTR);
      start_bad_s = start && !abort && (state_r == ST_IDLE) && (mode > MODE_CTR);
      in_fire_s   = in_valid && in_ready_r;
      done_s      = core_done && (state_r == ST_CORE);
      out_fire_s  = out_valid_r && out_ready;
   end

   // Next-state logic; abort overrides every transition.
   always_comb begin
      state_nxt_s = state_r;
      if (abort) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE:    state_nxt_s = start_ok_s ? ST_WAIT_IN : ST_IDLE;
            ST_WAIT_IN: state_nxt_s = in_fire_s  ? ST_CORE    : ST_WAIT_IN;
            ST_CORE:    state_nxt_s = done_s     ? ST_OUT     : ST_CORE;
            ST_OUT: begin
               if (out_fire_s) begin
                  state_nxt_s = out_last_r ? ST_IDLE : ST_WAIT_IN;
               end else begin
                  state_nxt_s = ST_OUT;
               end
            end
            default:    state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Handshake/status outputs registered from the next state so they track the FSM exactly.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_ready_r   <= 1'b0;
         out_valid_r  <= 1'b0;
         busy_r       <= 1'b0;
         core_start_r <= 1'b0;
      end else begin
         in_ready_r   <= (state_nxt_s == ST_WAIT_IN);
         out_valid_r  <= (state_nxt_s == ST_OUT);
         busy_r       <= (state_nxt_s != ST_IDLE);
         core_start_r <= in_fire_s && !abort;
      end
   end

   // Core input selection for the block being accepted; stream modes always run the core forward.
   always_comb begin
      din_s      = in_data;
      core_dec_s = decipher_r;
      case (mode_r)
         MODE_ECB: begin
            din_s      = in_data;
            core_dec_s = decipher_r;
         end
         MODE_CBC: begin
            din_s      = decipher_r ? in_data : (in_data ^ chain_r);
            core_dec_s = decipher_r;
         end
         MODE_CFB, MODE_OFB, MODE_CTR: begin
            din_s      = chain_r;
            core_dec_s = 1'b0;
         end
         default: begin
            din_s      = in_data;
            core_dec_s = decipher_r;
         end
      endcase
   end

   // Result and next chaining value when the core finishes a block.
   always_comb begin
      ctr_inc_s   = chain_r[CTR_W-1:0] + CTR_W'(1);
      res_s       = core_dout;
      chain_upd_s = chain_r;
      case (mode_r)
         MODE_ECB: begin
            res_s       = core_dout;
            chain_upd_s = chain_r;
         end
         MODE_CBC: begin
            res_s       = decipher_r ? (core_dout ^ chain_r) : core_dout;
            chain_upd_s = decipher_r ? in_data_r : core_dout;
         end
         MODE_CFB: begin
            res_s       = core_dout ^ in_data_r;
            chain_upd_s = decipher_r ? in_data_r : (core_dout ^ in_data_r);
         end
         MODE_OFB: begin
            res_s       = core_dout ^ in_data_r;
            chain_upd_s = core_dout;
         end
         MODE_CTR: begin
            res_s                    = core_dout ^ in_data_r;
            chain_upd_s              = chain_r;
            chain_upd_s[CTR_W-1:0]   = ctr_inc_s;
         end
         default: begin
            res_s       = core_dout;
            chain_upd_s = chain_r;
         end
      endcase
   end

   // Datapath: message setup, block capture, result/chain update and block counting.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_r          <= 3'd0;
         decipher_r      <= 1'b0;
         chain_r         <= '0;
         in_data_r       <= '0;
         in_last_r       <= 1'b0;
         out_data_r      <= '0;
         out_last_r      <= 1'b0;
         core_din_r      <= '0;
         core_decipher_r <= 1'b0;
         err_mode_r      <= 1'b0;
         blk_cnt_r       <= '0;
      end else if (abort) begin
         chain_r <= '0;
      end else begin
         if (start_ok_s) begin
            mode_r     <= mode;
            decipher_r <= decipher;
            chain_r    <= init_vector;
            blk_cnt_r  <= '0;
            err_mode_r <= 1'b0;
         end else if (start_bad_s) begin
            err_mode_r <= 1'b1;
         end
         if (in_fire_s) begin
            in_data_r       <= in_data;
            in_last_r       <= in_last;
            core_din_r      <= din_s;
            core_decipher_r <= core_dec_s;
         end
         if (done_s) begin
            out_data_r <= res_s;
            out_last_r <= in_last_r;
            chain_r    <= chain_upd_s;
         end
         if (out_fire_s) begin
            blk_cnt_r <= blk_cnt_r + CNT_W'(1);
         end
      end
   end

   assign in_ready      = in_ready_r;
   assign out_valid     = out_valid_r;
   assign out_data      = out_data_r;
   assign out_last      = out_last_r;
   assign core_start    = core_start_r;
   assign core_decipher = core_decipher_r;
   assign core_din      = core_din_r;
   assign busy          = busy_r;
   assign err_mode      = err_mode_r;
   assign blk_cnt       = blk_cnt_r;

endmodule

// File: tb/tb_aes_mode_stream_ctrl.sv
// Bench for aes_mode_stream_ctrl: behavioural AES-128 core plus a mode-level reference model.
module tb_aes_mode_stream_ctrl;

   logic         clk, rst_n, start, abort, decipher;
   logic [2:0]   mode;
   logic [127:0] init_vector, in_data, out_data, core_din, core_dout;
   logic         in_valid, in_ready, in_last, out_valid, out_ready, out_last;
   logic         core_start, core_decipher, core_done, busy, err_mode;
   logic [15:0]  blk_cnt;

   int n_tests, n_fail;

   aes_mode_stream_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .decipher(decipher),
      .mode(mode), .init_vector(init_vector), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .core_start(core_start),
      .core_decipher(core_decipher), .core_din(core_din), .core_dout(core_dout),
      .core_done(core_done), .busy(busy), .err_mode(err_mode), .blk_cnt(blk_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #(600000);
      $display("FAIL watchdog: simulation time exceeded, want completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- behavioural AES-128 ----------------
   logic [7:0]   sbox [256];
   logic [7:0]   isbox [256];
   logic [127:0] rk [11];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00; x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   task automatic build_aes();
      logic [7:0]  x, r, s, a, rc;
      logic [31:0] w [44];
      logic [31:0] t;
      logic [127:0] key;
      for (int v = 0; v < 256; v++) begin
         x = 8'(v); r = 8'h01; s = x;
         for (int k = 0; k < 7; k++) begin
            s = gmul(s, s);
            r = gmul(r, s);
         end
         a = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
         sbox[v]  = a;
         isbox[a] = x;
      end
      key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h000000};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r2 = 0; r2 < 11; r2++) rk[r2] = {w[4*r2], w[4*r2+1], w[4*r2+2], w[4*r2+3]};
   endtask

   function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
      logic [127:0] o;
      for (int i = 0; i < 16; i++)
         o[127-8*i -: 8] = inv ? isbox[s[127-8*i -: 8]] : sbox[s[127-8*i -: 8]];
      return o;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*(inv ? (c+4-r)%4 : (c+r)%4)) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s, input bit inv);
      logic [127:0] o;
      logic [7:0] cf [4];
      logic [7:0] a [4];
      logic [7:0] acc;
      if (inv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 4; k++) a[k] = s[127-8*(4*c+k) -: 8];
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc = acc ^ gmul(cf[(k-r+4)%4], a[k]);
            o[127-8*(4*c+r) -: 8] = acc;
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] aes_enc(input logic [127:0] p);
      logic [127:0] s;
      s = p ^ rk[0];
      for (int r = 1; r < 10; r++) s = mix_columns(shift_rows(sub_bytes(s, 1'b0), 1'b0), 1'b0) ^ rk[r];
      return shift_rows(sub_bytes(s, 1'b0), 1'b0) ^ rk[10];
   endfunction

   function automatic logic [127:0] aes_dec(input logic [127:0] c);
      logic [127:0] s;
      s = c ^ rk[10];
      for (int r = 9; r > 0; r--) s = mix_columns(sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk[r], 1'b1);
      return sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk[0];
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- AES core model: done 12 cycles after start ----------------
   bit           core_busy = 1'b0;
   bit           spur_en = 1'b0;
   int           core_cnt = 0;
   int           n_cs = 0;
   logic [127:0] core_res;

   always @(negedge clk) begin
      core_done = 1'b0;
      if (core_busy) begin
         core_cnt = core_cnt - 1;
         if (core_cnt == 0) begin
            core_done = 1'b1;
            core_dout = core_res;
            core_busy = 1'b0;
         end
      end
      if (core_start === 1'b1) begin
         n_cs      = n_cs + 1;
         core_busy = 1'b1;
         core_cnt  = 12;
         core_res  = core_decipher ? aes_dec(core_din) : aes_enc(core_din);
      end else if (spur_en && !core_busy && !core_done && ($urandom_range(0, 2) == 0)) begin
         core_done = 1'b1;
         core_dout = rand128();
      end
   end

   // ---------------- stimulus and reference model ----------------
   logic [127:0] in_blk [16];
   logic [127:0] exp_blk [16];
   logic [127:0] got_blk [16];
   logic         got_last [16];

   task automatic ref_msg(input logic [2:0] m, input bit d, input logic [127:0] iv, input int n);
      logic [127:0] fb, ctr;
      fb = iv;
      for (int i = 0; i < n; i++) begin
         case (m)
            3'd0: exp_blk[i] = d ? aes_dec(in_blk[i]) : aes_enc(in_blk[i]);
            3'd1: begin
               if (!d) begin exp_blk[i] = aes_enc(in_blk[i] ^ fb); fb = exp_blk[i]; end
               else begin exp_blk[i] = aes_dec(in_blk[i]) ^ fb; fb = in_blk[i]; end
            end
            3'd2: begin exp_blk[i] = in_blk[i] ^ aes_enc(fb); fb = d ? in_blk[i] : exp_blk[i]; end
            3'd3: begin fb = aes_enc(fb); exp_blk[i] = in_blk[i] ^ fb; end
            default: begin
               ctr = iv; ctr[31:0] = iv[31:0] + 32'(i);
               exp_blk[i] = in_blk[i] ^ aes_enc(ctr);
            end
         endcase
      end
   endtask

   task automatic do_start(input logic [2:0] m, input bit d, input logic [127:0] iv);
      @(negedge clk);
      start = 1'b1; mode = m; decipher = d; init_vector = iv;
      @(negedge clk);
      start = 1'b0; mode = 3'($urandom); decipher = 1'($urandom); init_vector = rand128();
   endtask

   task automatic send_msg(input int n, input bit rnd, input bit with_last);
      int cyc;
      for (int i = 0; i < n; i++) begin
         if (rnd) repeat ($urandom_range(0, 3)) @(negedge clk);
         in_valid = 1'b1; in_data = in_blk[i]; in_last = with_last && (i == n - 1);
         cyc = 0;
         while (in_ready !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
         if (in_ready !== 1'b1) begin
            n_tests++; n_fail++; in_valid = 1'b0;
            $display("FAIL in_ready_timeout: block %0d in_ready=%b want 1", i, in_ready);
            return;
         end
         @(negedge clk);
         in_valid = 1'b0; in_data = rand128(); in_last = 1'($urandom);
         cyc = 0;
         while (out_valid !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
         if (out_valid !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL out_valid_timeout: block %0d out_valid=%b want 1", i, out_valid);
            return;
         end
         if (rnd) repeat ($urandom_range(0, 3)) @(negedge clk);
         got_blk[i] = out_data; got_last[i] = out_last;
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({in_ready, out_valid, out_last, core_start, core_decipher, busy, err_mode} !== 7'd0) begin
         n_fail++; $display("FAIL reset_flags: got %b want 0000000",
            {in_ready, out_valid, out_last, core_start, core_decipher, busy, err_mode});
      end
      n_tests++;
      if (blk_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_blk_cnt: got %0d want 0", blk_cnt); end
      n_tests++;
      if (out_data !== 128'd0 || core_din !== 128'd0) begin
         n_fail++; $display("FAIL reset_data: out_data=%h core_din=%h want 0", out_data, core_din);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_ecb();
      int cs0;
      cs0 = n_cs;
      in_blk[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
      do_start(3'd0, 1'b0, rand128());
      send_msg(1, 1'b0, 1'b1);
      n_tests++;
      if (got_blk[0] !== 128'h3ad77bb40d7a3660a89ecaf32466ef97) begin
         n_fail++; $display("FAIL ecb_enc: got %h want 3ad77bb40d7a3660a89ecaf32466ef97", got_blk[0]);
      end
      n_tests++;
      if (got_last[0] !== 1'b1 || blk_cnt !== 16'd1) begin
         n_fail++; $display("FAIL ecb_last_cnt: last=%b cnt=%0d want 1 1", got_last[0], blk_cnt);
      end
      n_tests++;
      if (n_cs - cs0 !== 1) begin n_fail++; $display("FAIL ecb_core_start_pulses: got %0d want 1", n_cs - cs0); end
      in_blk[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
      do_start(3'd0, 1'b1, rand128());
      send_msg(1, 1'b0, 1'b1);
      n_tests++;
      if (got_blk[0] !== 128'h6bc1bee22e409f96e93d7e117393172a) begin
         n_fail++; $display("FAIL ecb_dec: got %h want 6bc1bee22e409f96e93d7e117393172a", got_blk[0]);
      end
   endtask

   task automatic test_cbc();
      in_blk[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
      in_blk[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
      do_start(3'd1, 1'b0, 128'h000102030405060708090a0b0c0d0e0f);
      // a start while a message is open must be ignored
      @(negedge clk); start = 1'b1; mode = 3'd0; init_vector = 128'd0;
      @(negedge clk); start = 1'b0;
      send_msg(2, 1'b0, 1'b1);
      n_tests++;
      if (got_blk[0] !== 128'h7649abac8119b246cee98e9b12e9197d) begin
         n_fail++; $display("FAIL cbc_enc_b0: got %h want 7649abac8119b246cee98e9b12e9197d", got_blk[0]);
      end
      n_tests++;
      if (got_blk[1] !== 128'h5086cb9b507219ee95db113a917678b2) begin
         n_fail++; $display("FAIL cbc_enc_b1: got %h want 5086cb9b507219ee95db113a917678b2", got_blk[1]);
      end
      n_tests++;
      if ({got_last[0], got_last[1]} !== 2'b01 || blk_cnt !== 16'd2 || busy !== 1'b0) begin
         n_fail++; $display("FAIL cbc_framing: last=%b%b cnt=%0d busy=%b want 01 2 0",
            got_last[0], got_last[1], blk_cnt, busy);
      end
      in_blk[0] = 128'h7649abac8119b246cee98e9b12e9197d;
      in_blk[1] = 128'h5086cb9b507219ee95db113a917678b2;
      do_start(3'd1, 1'b1, 128'h000102030405060708090a0b0c0d0e0f);
      send_msg(2, 1'b1, 1'b1);
      n_tests++;
      if (got_blk[0] !== 128'h6bc1bee22e409f96e93d7e117393172a || got_blk[1] !== 128'hae2d8a571e03ac9c9eb76fac45af8e51) begin
         n_fail++; $display("FAIL cbc_dec: got %h %h want 6bc1..172a ae2d..8e51", got_blk[0], got_blk[1]);
      end
   endtask

   task automatic test_ctr();
      logic [127:0] iv;
      in_blk[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
      in_blk[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
      do_start(3'd4, 1'b0, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff);
      send_msg(2, 1'b0, 1'b1);
      n_tests++;
      if (got_blk[0] !== 128'h874d6191b620e3261bef6864990db6ce || got_blk[1] !== 128'h9806f66b7970fdff8617187bb9fffdff) begin
         n_fail++; $display("FAIL ctr_vec: got %h %h want 874d..b6ce 9806..fdff", got_blk[0], got_blk[1]);
      end
      // low counter word wraps; upper bits must stay fixed
      iv = rand128(); iv[31:0] = 32'hffff_fffe;
      for (int i = 0; i < 3; i++) in_blk[i] = rand128();
      ref_msg(3'd4, 1'b1, iv, 3);
      do_start(3'd4, 1'b1, iv);
      send_msg(3, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (got_blk[i] !== exp_blk[i]) begin
            n_fail++; $display("FAIL ctr_wrap_b%0d: got %h want %h", i, got_blk[i], exp_blk[i]);
         end
      end
   endtask

   task automatic test_ofb_cfb();
      in_blk[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
      in_blk[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
      do_start(3'd3, 1'b0, 128'h000102030405060708090a0b0c0d0e0f);
      send_msg(2, 1'b0, 1'b1);
      n_tests++;
      if (got_blk[0] !== 128'h3b3fd92eb72dad20333449f8e83cfb4a || got_blk[1] !== 128'h7789508d16918f03f53c52dac54ed825) begin
         n_fail++; $display("FAIL ofb_vec: got %h %h want 3b3f..fb4a 7789..d825", got_blk[0], got_blk[1]);
      end
      do_start(3'd2, 1'b0, 128'h000102030405060708090a0b0c0d0e0f);
      send_msg(1, 1'b0, 1'b1);
      n_tests++;
      if (got_blk[0] !== 128'h3b3fd92eb72dad20333449f8e83cfb4a) begin
         n_fail++; $display("FAIL cfb_enc: got %h want 3b3fd92eb72dad20333449f8e83cfb4a", got_blk[0]);
      end
      in_blk[0] = 128'h3b3fd92eb72dad20333449f8e83cfb4a;
      do_start(3'd2, 1'b1, 128'h000102030405060708090a0b0c0d0e0f);
      send_msg(1, 1'b0, 1'b1);
      n_tests++;
      if (got_blk[0] !== 128'h6bc1bee22e409f96e93d7e117393172a) begin
         n_fail++; $display("FAIL cfb_dec: got %h want 6bc1bee22e409f96e93d7e117393172a", got_blk[0]);
      end
   endtask

   task automatic test_backpressure();
      int cyc, cs0;
      bit stable_ok;
      do_start(3'd0, 1'b0, rand128());
      in_valid = 1'b1; in_data = 128'h6bc1bee22e409f96e93d7e117393172a; in_last = 1'b1;
      cyc = 0;
      while (in_ready !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
      // offer another block during the stall; it must not be taken
      in_valid = 1'b1; in_data = rand128(); in_last = 1'b0;
      cs0 = n_cs; stable_ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || out_data !== 128'h3ad77bb40d7a3660a89ecaf32466ef97 ||
             out_last !== 1'b1 || in_ready !== 1'b0) stable_ok = 1'b0;
      end
      n_tests++;
      if (stable_ok !== 1'b1) begin
         n_fail++; $display("FAIL bp_stable: out_valid=%b out_data=%h in_ready=%b want 1 3ad77bb4.. 0",
            out_valid, out_data, in_ready);
      end
      n_tests++;
      if (n_cs !== cs0) begin n_fail++; $display("FAIL bp_core_start: got %0d pulses want 0", n_cs - cs0); end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || blk_cnt !== 16'd1) begin
         n_fail++; $display("FAIL bp_release: out_valid=%b busy=%b cnt=%0d want 0 0 1", out_valid, busy, blk_cnt);
      end
   endtask

   task automatic test_abort();
      bit quiet;
      in_blk[0] = rand128();
      do_start(3'd1, 1'b0, 128'h000102030405060708090a0b0c0d0e0f);
      send_msg(1, 1'b0, 1'b0);
      in_valid = 1'b1; in_data = rand128(); in_last = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_tests++;
      if ({busy, in_ready, out_valid, core_start} !== 4'b0000 || blk_cnt !== 16'd1) begin
         n_fail++; $display("FAIL abort_state: busy/in_ready/out_valid/core_start=%b cnt=%0d want 0000 1",
            {busy, in_ready, out_valid, core_start}, blk_cnt);
      end
      quiet = 1'b1;
      repeat (20) begin @(negedge clk); if (out_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0; end
      n_tests++;
      if (quiet !== 1'b1) begin n_fail++; $display("FAIL abort_drop: late core result surfaced, want none"); end
      @(negedge clk); start = 1'b1; abort = 1'b1; mode = 3'd1;
      @(negedge clk); start = 1'b0; abort = 1'b0;
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_start_same: busy=%b want 0", busy); end
      in_blk[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
      do_start(3'd1, 1'b0, 128'h000102030405060708090a0b0c0d0e0f);
      send_msg(1, 1'b0, 1'b1);
      n_tests++;
      if (got_blk[0] !== 128'h7649abac8119b246cee98e9b12e9197d || blk_cnt !== 16'd1) begin
         n_fail++; $display("FAIL abort_restart: got %h cnt=%0d want 7649abac8119b246cee98e9b12e9197d 1",
            got_blk[0], blk_cnt);
      end
   endtask

   task automatic test_err_mode();
      bit quiet;
      in_blk[0] = rand128();
      do_start(3'd0, 1'b0, rand128());
      send_msg(1, 1'b0, 1'b1);
      do_start(3'd5, 1'b0, rand128());
      n_tests++;
      if (err_mode !== 1'b1 || busy !== 1'b0 || blk_cnt !== 16'd1) begin
         n_fail++; $display("FAIL err_set: err=%b busy=%b cnt=%0d want 1 0 1", err_mode, busy, blk_cnt);
      end
      do_start(3'd2, 1'b0, rand128());
      n_tests++;
      if (err_mode !== 1'b0 || busy !== 1'b1 || blk_cnt !== 16'd0) begin
         n_fail++; $display("FAIL err_clear: err=%b busy=%b cnt=%0d want 0 1 0", err_mode, busy, blk_cnt);
      end
      send_msg(1, 1'b0, 1'b1);
      do_start(3'd7, 1'b1, rand128());
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_tests++;
      if (err_mode !== 1'b0 || blk_cnt !== 16'd0) begin
         n_fail++; $display("FAIL reset_clears: err=%b cnt=%0d want 0 0", err_mode, blk_cnt);
      end
      // reset while a block is inside the core
      do_start(3'd0, 1'b0, rand128());
      in_valid = 1'b1; in_data = rand128(); in_last = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      quiet = 1'b1;
      repeat (20) begin @(negedge clk); if (out_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0; end
      n_tests++;
      if (quiet !== 1'b1) begin n_fail++; $display("FAIL reset_midop: out_valid=%b busy=%b want 0 0", out_valid, busy); end
   endtask

   task automatic run_random(input int msgs);
      logic [2:0] m; bit d; logic [127:0] iv; int n;
      for (int k = 0; k < msgs; k++) begin
         m = 3'($urandom_range(0, 4)); d = 1'($urandom); iv = rand128(); n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) in_blk[i] = rand128();
         ref_msg(m, d, iv, n);
         do_start(m, d, iv);
         send_msg(n, 1'b1, 1'b1);
         for (int i = 0; i < n; i++) begin
            n_tests++;
            if (got_blk[i] !== exp_blk[i] || got_last[i] !== (i == n - 1)) begin
               n_fail++; $display("FAIL rnd_m%0d_d%0d_b%0d: got %h last=%b want %h last=%b",
                  m, d, i, got_blk[i], got_last[i], exp_blk[i], (i == n - 1));
            end
         end
         n_tests++;
         if (blk_cnt !== 16'(n)) begin n_fail++; $display("FAIL rnd_blk_cnt: got %0d want %0d", blk_cnt, n); end
      end
   endtask

   task automatic test_spurious_done();
      spur_en = 1'b1;
      run_random(4);
      spur_en = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_random();
      run_random(25);
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; decipher = 1'b0; mode = 3'd0;
      init_vector = 128'd0; in_valid = 1'b0; in_data = 128'd0; in_last = 1'b0;
      out_ready = 1'b0; core_done = 1'b0; core_dout = 128'd0;
      build_aes();
      test_reset();
      test_ecb();
      test_cbc();
      test_ctr();
      test_ofb_cfb();
      test_backpressure();
      test_abort();
      test_err_mode();
      test_spurious_done();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
